seq_event_counter: RTL and testbench

SEQ_EVENT_COUNTER -- requirements
Module: seq_event_counter

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_event_counter_if.sv | 11 +
 rtl/sat_counter.sv | 20 ++
 rtl/seq_event_counter.sv | 107 ++++++++++
 tb/tb_seq_event_counter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 detector and the windowed event counter stages.
package seq_det_pkg;

    localparam int unsigned TOTAL_W = 16;

    typedef enum logic {
        StIdle,
        StRun
    } cnt_state_e;

    // Encodings of the upstream 1011 sequence-detector stage.
    typedef enum logic [1:0] {
        DetS0,
        DetS1,
        DetS10,
        DetS101
    } det_state_e;

endpackage

// File: rtl/seq_event_counter_if.sv
// Window-result handshake: producer drives count/valid, consumer drives ready.
interface seq_event_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic [CNT_W-1:0] win_cnt;
    logic             win_valid;
    logic             win_ready;

    modport master (output win_cnt, output win_valid, input win_ready);
    modport slave  (input win_cnt, input win_valid, output win_ready);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; sync clear has priority.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/seq_event_counter.sv
// Counts detector pulses over fixed windows of WIN_CYCLES and hands each window's
// total to a consumer through a valid/ready register, plus a saturating grand total.
module seq_event_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned WIN_CYCLES = 256,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                det_in,
    input  logic                en,
    input  logic                clr,
    seq_event_counter_if.master res,
    output logic [TOTAL_W-1:0]  total_cnt,
    output logic                overrun,
    output logic                busy
);
    localparam int unsigned TW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(WIN_CYCLES - 1);

    cnt_state_e       state_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic             win_valid_q;
    logic             overrun_q;

    logic             run;
    logic             complete;
    logic             acc_clr;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] win_final;

    assign run      = (state_q == StRun);
    assign complete = run && (timer_q == LAST);
    // Accumulator only carries across cycles that stay inside an enabled window.
    assign acc_clr  = clr || !run || !en || complete;

    // The last cycle's pulse must land in the result on the same edge the window closes.
    assign win_final = (det_in && (acc_cnt != {CNT_W{1'b1}})) ? acc_cnt + CNT_W'(1) : acc_cnt;

    sat_counter #(.W(CNT_W)) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .inc (run && det_in),
        .cnt (acc_cnt)
    );

    sat_counter #(.W(TOTAL_W)) u_total (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (run && det_in),
        .cnt (total_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            win_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (clr) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            win_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StRun;
                        timer_q <= '0;
                    end
                end
                StRun: begin
                    if (!en) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                    end else begin
                        timer_q <= complete ? '0 : timer_q + TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (complete) begin
                if (!win_valid_q || res.win_ready) begin
                    win_cnt_q   <= win_final;
                    win_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (win_valid_q && res.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign res.win_cnt   = win_cnt_q;
    assign res.win_valid = win_valid_q;
    assign overrun       = overrun_q;
    assign busy          = run;
endmodule

// File: tb/tb_seq_event_counter.sv
// Directed window scenarios plus random traffic, checked each cycle against a count-based model.
module tb_seq_event_counter;
    import seq_det_pkg::*;

    localparam int unsigned WIN   = 8;
    localparam int unsigned CW    = 3;
    localparam int          WMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic det_in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic [TOTAL_W-1:0] total_cnt;
    logic overrun;
    logic busy;

    seq_event_counter_if #(.CNT_W(CW)) res_if ();

    seq_event_counter #(.WIN_CYCLES(WIN), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .det_in    (det_in),
        .en        (en),
        .clr       (clr),
        .res       (res_if),
        .total_cnt (total_cnt),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: plain integer counts, saturation applied only when a value is reported.
    int m_run, m_pos, m_hits, m_total, m_wcnt, m_wvalid, m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_hits = 0; m_total = 0;
        m_wcnt = 0; m_wvalid = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        int  res;
        bit  done;
        if (clr) begin
            model_reset();
            return;
        end
        res  = 0;
        done = (m_run != 0) && (m_pos == WIN - 1);
        if (m_run != 0) begin
            if (det_in) begin
                m_hits++;
                if (m_total < 65535) m_total++;
            end
            res = (m_hits > WMAX) ? WMAX : m_hits;
        end
        if (done) begin
            if (m_wvalid == 0 || res_if.win_ready) begin
                m_wcnt = res;
                m_wvalid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_wvalid != 0 && res_if.win_ready) begin
            m_wvalid = 0;
        end
        if (m_run != 0) begin
            if (!en) begin
                m_run = 0; m_pos = 0; m_hits = 0;
            end else if (done) begin
                m_pos = 0; m_hits = 0;
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_run = 1; m_pos = 0; m_hits = 0;
        end
    endtask

    task automatic check_all();
        check("win_cnt",   32'(res_if.win_cnt),   32'(m_wcnt));
        check("win_valid", 32'(res_if.win_valid), 32'(m_wvalid));
        check("total_cnt", 32'(total_cnt),        32'(m_total));
        check("overrun",   32'(overrun),          32'(m_ovr));
        check("busy",      32'(busy),             32'(m_run));
    endtask

    task automatic cyc(input logic d, input logic e, input logic c, input logic r);
        det_in = d;
        en = e;
        clr = c;
        res_if.win_ready = r;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_window(input logic [7:0] dmask, input logic [7:0] rmask);
        for (int t = 0; t < 8; t++) cyc(dmask[t], 1'b1, 1'b0, rmask[t]);
    endtask

    initial begin
        res_if.win_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Two hits at timer 2 and 5.
        cyc(0, 1, 0, 1);
        run_window(8'b0010_0100, 8'hFF);
        check("w33_cnt", 32'(res_if.win_cnt), 32'd2);
        check("w33_valid", 32'(res_if.win_valid), 32'd1);
        check("w33_total", 32'(total_cnt), 32'd2);
        cyc(0, 0, 0, 1);
        check("w33_valid_drop", 32'(res_if.win_valid), 32'd0);

        // Every cycle hits: window saturates, total does not.
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        run_window(8'hFF, 8'hFF);
        check("w34_cnt", 32'(res_if.win_cnt), 32'd7);
        check("w34_total", 32'(total_cnt), 32'd8);

        // Consumer stalls across two windows.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        run_window(8'b0000_0001, 8'h00);
        run_window(8'b0010_1010, 8'h00);
        check("w35_cnt", 32'(res_if.win_cnt), 32'd1);
        check("w35_ovr", 32'(overrun), 32'd1);
        cyc(0, 0, 0, 1);
        check("w35_valid_drop", 32'(res_if.win_valid), 32'd0);
        check("w35_ovr_sticky", 32'(overrun), 32'd1);

        // Accept on the same edge window 2 completes.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        run_window(8'b0000_0001, 8'h00);
        run_window(8'b0010_1010, 8'b1000_0000);
        check("w36_cnt", 32'(res_if.win_cnt), 32'd3);
        check("w36_valid", 32'(res_if.win_valid), 32'd1);
        check("w36_ovr", 32'(overrun), 32'd0);

        // Enable dropped at timer 4, then restart from 0.
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        for (int t = 0; t < 4; t++) cyc(logic'(t == 1 || t == 2), 1'b1, 1'b0, 1'b1);
        cyc(0, 0, 0, 1);
        check("w37_busy", 32'(busy), 32'd0);
        check("w37_valid", 32'(res_if.win_valid), 32'd0);
        cyc(0, 1, 0, 1);
        run_window(8'b0100_0000, 8'hFF);
        check("w37_cnt", 32'(res_if.win_cnt), 32'd1);
        check("w37_total", 32'(total_cnt), 32'd3);

        // Asynchronous reset with a pending result.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        run_window(8'b0001_1111, 8'h00);
        check("w38_pre_total", 32'(total_cnt), 32'd5);
        check("w38_pre_valid", 32'(res_if.win_valid), 32'd1);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("w38_rst_cnt", 32'(res_if.win_cnt), 32'd0);
        check("w38_rst_valid", 32'(res_if.win_valid), 32'd0);
        check("w38_rst_total", 32'(total_cnt), 32'd0);
        check("w38_rst_busy", 32'(busy), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 0, 1);
        run_window(8'b0000_0001, 8'hFF);
        check("w38_after_rst", 32'(res_if.win_cnt), 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        run_window(8'b0001_1111, 8'h00);
        cyc(1, 1, 1, 1);
        check("w38_clr_cnt", 32'(res_if.win_cnt), 32'd0);
        check("w38_clr_valid", 32'(res_if.win_valid), 32'd0);
        check("w38_clr_total", 32'(total_cnt), 32'd0);
        check("w38_clr_busy", 32'(busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0),
                ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
